// File: rtl/hyperbus_arbiter.sv
// rtl/hyperbus_arbiter.sv - round-robin sequencer sharing one hyperbus controller
// Grants one port at a time, runs exactly len words over wrq/rrq, then idles for a guard gap.
module hyperbus_arbiter #(
   parameter int NPORTS      = 2,
   parameter int WIDTH       = 8,
   parameter int ADDR_LENGTH = 32,
   parameter int LEN_WIDTH   = 8,
   parameter int GAP_COUNT   = 4,
   parameter int TIMEOUT     = 255
) (
   input  logic                               clk,
   input  logic                               rstn,
   input  logic [NPORTS-1:0]                  req,
   input  logic [NPORTS-1:0]                  we,
   input  logic [NPORTS-1:0]                  reg_space,
   input  logic [NPORTS*ADDR_LENGTH-1:0]      adr,
   input  logic [NPORTS*LEN_WIDTH-1:0]        len,
   input  logic [NPORTS*2*WIDTH-1:0]          wdat,
   input  logic [NPORTS*(2*WIDTH/8)-1:0]      wmask,
   output logic [NPORTS-1:0]                  wr_ready,
   output logic [2*WIDTH-1:0]                 rd_dat,
   output logic [NPORTS-1:0]                  rd_valid,
   output logic [NPORTS-1:0]                  gnt,
   output logic [NPORTS-1:0]                  done,
   output logic [NPORTS-1:0]                  err,
   output logic [ADDR_LENGTH-1:0]             hb_adr,
   output logic [2*WIDTH-1:0]                 hb_dat,
   output logic [2*WIDTH/8-1:0]               hb_mask,
   output logic                               hb_reg_space,
   output logic                               hb_wrq,
   output logic                               hb_rrq,
   input  logic                               hb_ready,
   input  logic                               hb_valid,
   input  logic [2*WIDTH-1:0]                 hb_rdat
);

   localparam int W  = 2 * WIDTH;
   localparam int MW = W / 8;
   localparam int PW = $clog2(NPORTS);
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam int GW = $clog2(GAP_COUNT + 1) + 1;
   localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);
   localparam logic [GW-1:0] GAP_LAST = GW'((GAP_COUNT > 0) ? GAP_COUNT - 1 : 0);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      XFER = 2'd1,
      GAP  = 2'd2
   } state_t;

   state_t                 state_q, state_d;
   logic [PW-1:0]          rr_q, rr_d;
   logic [PW-1:0]          g_q, g_d;
   logic                   we_q, we_d;
   logic                   reg_q, reg_d;
   logic [ADDR_LENGTH-1:0] adr_q, adr_d;
   logic [LEN_WIDTH-1:0]   words_q, words_d;
   logic [TW-1:0]          wait_q, wait_d;
   logic [GW-1:0]          gap_q, gap_d;
   logic                   rrq_q, rrq_d;
   logic [NPORTS-1:0]      done_q, done_d;
   logic [NPORTS-1:0]      err_q, err_d;

   logic [PW-1:0]          pick;
   logic                   found;
   logic [PW-1:0]          rr_next;
   logic [LEN_WIDTH-1:0]   len_pick;
   logic                   fin, fin_err;
   logic                   in_xfer, wrq_act, last_word;

   // First requester at or after the rr pointer, wrapping around.
   always_comb begin
      int k;
      k     = 0;
      pick  = '0;
      found = 1'b0;
      for (int i = 0; i < NPORTS; i++) begin
         k = int'(rr_q) + i;
         if (k >= NPORTS) k = k - NPORTS;
         if (!found && req[k]) begin
            found = 1'b1;
            pick  = PW'(k);
         end
      end
   end

   assign rr_next  = (g_q == PW'(NPORTS - 1)) ? '0 : g_q + 1'b1;
   assign len_pick = len[int'(pick)*LEN_WIDTH +: LEN_WIDTH];

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q <= IDLE;
         rr_q    <= '0;
         g_q     <= '0;
         we_q    <= 1'b0;
         reg_q   <= 1'b0;
         adr_q   <= '0;
         words_q <= '0;
         wait_q  <= '0;
         gap_q   <= '0;
         rrq_q   <= 1'b0;
         done_q  <= '0;
         err_q   <= '0;
      end else begin
         state_q <= state_d;
         rr_q    <= rr_d;
         g_q     <= g_d;
         we_q    <= we_d;
         reg_q   <= reg_d;
         adr_q   <= adr_d;
         words_q <= words_d;
         wait_q  <= wait_d;
         gap_q   <= gap_d;
         rrq_q   <= rrq_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      rr_d    = rr_q;
      g_d     = g_q;
      we_d    = we_q;
      reg_d   = reg_q;
      adr_d   = adr_q;
      words_d = words_q;
      wait_d  = wait_q;
      gap_d   = gap_q;
      rrq_d   = rrq_q;
      done_d  = '0;
      err_d   = '0;
      fin     = 1'b0;
      fin_err = 1'b0;
      case (state_q)
         IDLE: begin
            if (found) begin
               g_d     = pick;
               we_d    = we[pick];
               reg_d   = reg_space[pick];
               adr_d   = adr[int'(pick)*ADDR_LENGTH +: ADDR_LENGTH];
               words_d = (len_pick == '0) ? LEN_WIDTH'(1) : len_pick;
               wait_d  = '0;
               rrq_d   = ~we[pick];
               state_d = XFER;
            end
         end
         XFER: begin
            if (we_q) begin
               if (hb_ready) begin
                  words_d = words_q - 1'b1;
                  fin     = (words_q == LEN_WIDTH'(1));
               end
            end else if (hb_valid) begin
               wait_d  = '0;
               words_d = words_q - 1'b1;
               fin     = (words_q == LEN_WIDTH'(1));
            end else if (wait_q == TO_LAST) begin
               fin     = 1'b1;
               fin_err = 1'b1;
            end else begin
               wait_d = wait_q + 1'b1;
            end
         end
         GAP: begin
            if (gap_q == GAP_LAST) state_d = IDLE;
            else gap_d = gap_q + 1'b1;
         end
         default: state_d = IDLE;
      endcase
      if (fin) begin
         state_d     = GAP;
         rrq_d       = 1'b0;
         done_d[g_q] = 1'b1;
         err_d[g_q]  = fin_err;
         gap_d       = '0;
         rr_d        = rr_next;
      end
   end

   assign in_xfer   = (state_q == XFER);
   assign last_word = (words_q == LEN_WIDTH'(1));
   assign wrq_act   = in_xfer & we_q & (words_q != '0);

   // The final accepted beat drops wrq in the same cycle so the controller sees no extra beat.
   assign hb_wrq       = wrq_act & ~(hb_ready & last_word);
   assign hb_rrq       = rrq_q;
   assign hb_adr       = adr_q;
   assign hb_reg_space = reg_q;
   assign hb_dat       = wdat[int'(g_q)*W +: W];
   assign hb_mask      = wmask[int'(g_q)*MW +: MW];
   assign rd_dat       = hb_rdat;
   assign done         = done_q;
   assign err          = err_q;

   always_comb begin
      gnt      = '0;
      wr_ready = '0;
      rd_valid = '0;
      if (in_xfer) begin
         gnt[g_q]      = 1'b1;
         wr_ready[g_q] = hb_ready & wrq_act;
         rd_valid[g_q] = hb_valid & ~we_q & (words_q != '0);
      end
   end

endmodule
